// File: rtl/mem_mon_pkg.sv
// Shared types for the data-memory write monitor: verdict encoding and trace entry layout.
package mem_mon_pkg;

  localparam int CYCLE_W = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } verdict_t;

  typedef struct packed {
    logic [31:0]        addr;
    logic [31:0]        data;
    logic [CYCLE_W-1:0] cycle;
  } trace_t;

  localparam int TRACE_W = $bits(trace_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, separate occupancy counter and no fall-through.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign count  = r_count;
  // Head is gated so the outputs read zero whenever nothing is queued.
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Watches the data-memory store bus, timestamps and queues each store, and decides pass/fail/timeout.
// state   | meaning
// RUN     | capturing stores, no verdict yet
// PASS    | completion store seen (terminal)
// FAIL    | store outside the scratch/done locations (terminal)
// TIMEOUT | no verdict within the cycle budget (terminal)
module mem_write_monitor
  import mem_mon_pkg::*;
#(
  parameter int          DEPTH          = 8,
  parameter logic [31:0] DONE_ADDR      = 32'd100,
  parameter logic [31:0] DONE_DATA      = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [31:0]                tr_addr,
  output logic [31:0]                tr_data,
  output logic [15:0]                tr_cycle,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout
);

  logic [CYCLE_W-1:0] r_cycle;
  verdict_t           r_state;
  logic               r_pass;
  logic               r_fail;
  logic               r_timeout;
  logic               r_done;
  logic               r_overflow;

  logic   w_capture;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;
  logic   w_is_pass;
  trace_t w_push_entry;
  trace_t w_head;

  assign w_capture    = MemWrite && (r_state == RUN);
  assign w_pop        = tr_valid && tr_ready;
  assign w_is_pass    = (DataAdr == DONE_ADDR) && (WriteData == DONE_DATA);
  assign w_push_entry = '{addr: DataAdr, data: WriteData, cycle: r_cycle};

  sync_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_capture),
    .pop   (w_pop),
    .din   (w_push_entry),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  assign tr_valid = !w_empty;
  assign tr_addr  = w_head.addr;
  assign tr_data  = w_head.data;
  assign tr_cycle = w_head.cycle;
  assign overflow = r_overflow;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign timeout  = r_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_cycle != '1) r_cycle <= r_cycle + CYCLE_W'(1);
      // A store is lost only when the queue is full and nothing leaves it this cycle.
      if (w_capture && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          // A qualifying store beats the timeout in the same cycle.
          if (MemWrite && w_is_pass) begin
            r_state <= PASS;
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
          end else if (MemWrite && (DataAdr != SCRATCH_ADDR)) begin
            r_state <= FAIL;
            r_fail  <= 1'b1;
            r_done  <= 1'b1;
          end else if (r_cycle == TIMEOUT_CYCLES - 16'd1) begin
            r_state   <= TIMEOUT;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule
